// File: rtl/dk_pkg.sv
// rtl/dk_pkg.sv - shared types and screen/sprite constants for the DK sprite controllers
package dk_pkg;

    typedef enum logic [1:0] {
        S_STAND = 2'd0,
        S_THROW = 2'd1,
        S_WALK  = 2'd2
    } dk_state_t;

    localparam logic [1:0] SPR_STAND = 2'b00;
    localparam logic [1:0] SPR_SIDE  = 2'b01;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] SPRITE_W = 10'd64;
    localparam logic [9:0] SPRITE_H = 10'd32;

endpackage

// File: rtl/dk_frame_tick.sv
// rtl/dk_frame_tick.sv - one-cycle pulse at the start of vertical blank
module dk_frame_tick
    import dk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] vcount,
    output logic       frame_tick
);

    logic vblank;
    logic vblank_q;

    assign vblank = (vcount >= V_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q <= 1'b0;
        end else begin
            vblank_q <= vblank;
        end
    end

    assign frame_tick = vblank & ~vblank_q;

endmodule

// File: rtl/dk_motion_ctrl.sv
// rtl/dk_motion_ctrl.sv - DK pacing/throw controller; DK_WALK_ANIM_EN enables walk pose animation
module dk_motion_ctrl
    import dk_pkg::*;
#(
    parameter int X_MIN        = 16,
    parameter int X_MAX        = 576,
    parameter int Y_POS        = 24,
    parameter int STEP         = 2,
    parameter int STAND_FRAMES = 60,
    parameter int ANIM_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       run,
    input  logic       barrel_ack,
    output logic [9:0] curr_h,
    output logic [9:0] curr_v,
    output logic [1:0] sprite_selec,
    output logic       bounds_draw,
    output logic       barrel_req
);

    localparam int          SCW    = $clog2(STAND_FRAMES + 1);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] STEP11 = 11'(STEP);

    dk_state_t        state, state_d;
    logic             dir, dir_d;
    logic [9:0]       h_d;
    logic [SCW-1:0]   stand_cnt, stand_cnt_d;
    logic             req_d;
    logic             run_q;
    logic             tick;
    logic             adv;
    logic [10:0]      h_right;
    logic [10:0]      h_left;
    logic [1:0]       walk_sel;

    dk_frame_tick u_frame_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .vcount     (vcount),
        .frame_tick (tick)
    );

    assign adv     = tick & run;
    // 11-bit sums so a step past either edge is detected instead of wrapping
    assign h_right = {1'b0, curr_h} + STEP11;
    assign h_left  = {1'b0, curr_h} - STEP11;

    always_comb begin
        state_d     = state;
        dir_d       = dir;
        h_d         = curr_h;
        stand_cnt_d = stand_cnt;
        req_d       = barrel_req;
        case (state)
            S_STAND: begin
                if (adv) begin
                    if (stand_cnt == SCW'(STAND_FRAMES - 1)) begin
                        stand_cnt_d = '0;
                        req_d       = 1'b1;
                        state_d     = S_THROW;
                    end else begin
                        stand_cnt_d = stand_cnt + 1'b1;
                    end
                end
            end
            S_THROW: begin
                // ack takes priority over a coincident tick: no step this cycle
                if (run && barrel_req && barrel_ack) begin
                    req_d   = 1'b0;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (adv) begin
                    if (!dir) begin
                        if (h_right >= XMAX11) begin
                            h_d     = 10'(X_MAX);
                            dir_d   = 1'b1;
                            state_d = S_STAND;
                        end else begin
                            h_d = h_right[9:0];
                        end
                    end else begin
                        if ({1'b0, curr_h} < XMIN11 + STEP11) begin
                            h_d     = 10'(X_MIN);
                            dir_d   = 1'b0;
                            state_d = S_STAND;
                        end else begin
                            h_d = h_left[9:0];
                        end
                    end
                end
            end
            default: state_d = S_STAND;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_STAND;
            dir        <= 1'b0;
            curr_h     <= 10'(X_MIN);
            stand_cnt  <= '0;
            barrel_req <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state      <= state_d;
            dir        <= dir_d;
            curr_h     <= h_d;
            stand_cnt  <= stand_cnt_d;
            barrel_req <= req_d;
            if (tick) begin
                run_q <= run;
            end
        end
    end

`ifdef DK_WALK_ANIM_EN
    localparam int AW = $clog2(ANIM_FRAMES + 1);

    logic [AW-1:0] anim_cnt;
    logic          anim_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_cnt   <= '0;
            anim_phase <= 1'b0;
        end else if (state == S_THROW && state_d == S_WALK) begin
            anim_cnt   <= '0;
            anim_phase <= 1'b0;
        end else if (adv && state == S_WALK) begin
            if (anim_cnt == AW'(ANIM_FRAMES - 1)) begin
                anim_cnt   <= '0;
                anim_phase <= ~anim_phase;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

    assign walk_sel = anim_phase ? SPR_STAND : SPR_SIDE;
`else
    assign walk_sel = SPR_SIDE;
`endif

    assign sprite_selec = (state == S_WALK) ? walk_sel : SPR_STAND;
    assign curr_v       = 10'(Y_POS);
    assign bounds_draw  = (hcount < H_ACTIVE) && (vcount < V_ACTIVE) && run_q;

endmodule

// File: tb/tb_dk_motion_ctrl.sv
// tb/tb_dk_motion_ctrl.sv - scoreboard bench for dk_motion_ctrl
module tb_dk_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       barrel_ack;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] curr_h;
    logic [9:0] curr_v;
    logic [1:0] sprite_selec;
    logic       bounds_draw;
    logic       barrel_req;

    always #5 clk = ~clk;

    dk_motion_ctrl #(
        .X_MIN(16), .X_MAX(202), .Y_POS(24), .STEP(4),
        .STAND_FRAMES(3), .ANIM_FRAMES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcount       (hcount),
        .vcount       (vcount),
        .run          (run),
        .barrel_ack   (barrel_ack),
        .curr_h       (curr_h),
        .curr_v       (curr_v),
        .sprite_selec (sprite_selec),
        .bounds_draw  (bounds_draw),
        .barrel_req   (barrel_req)
    );

    typedef struct {
        string      name;
        logic [9:0] h;
        logic [1:0] sel;
        logic       req;
        logic       draw;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m;
    int   checks = 0;
    int   passed = 0;
    int   wk     = 0;
    int   hx     = 16;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            checks++;
            if ({curr_h, curr_v, sprite_selec, barrel_req, bounds_draw} ===
                {e_m.h, 10'd24, e_m.sel, e_m.req, e_m.draw}) begin
                passed++;
            end else begin
                $display("FAIL %s: got h=%0d v=%0d sel=%b req=%b draw=%b, want h=%0d v=24 sel=%b req=%b draw=%b",
                         e_m.name, curr_h, curr_v, sprite_selec, barrel_req, bounds_draw,
                         e_m.h, e_m.sel, e_m.req, e_m.draw);
            end
        end
    end

    function automatic logic [1:0] wsel(int k);
`ifdef DK_WALK_ANIM_EN
        return ((k / 2) % 2 != 0) ? 2'b00 : 2'b01;
`else
        return (k >= 0) ? 2'b01 : 2'b01;
`endif
    endfunction

    task automatic expect_now(string n, int h, logic [1:0] s, logic r, logic d);
        exp_q.push_back('{n, 10'(h), s, r, d});
        @(negedge clk);
        #1;
    endtask

    task automatic frame();
        vcount = 10'd480;
        @(posedge clk);
        #1;
        vcount = 10'd100;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; barrel_ack = 1'b0;
        hcount = 10'd100; vcount = 10'd100;
        repeat (3) @(posedge clk);
        #1;
        expect_now("reset", 16, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 2; i++) begin
            frame();
            expect_now("stand", 16, 2'b00, 1'b0, 1'b1);
        end
        frame();
        expect_now("req_rise", 16, 2'b00, 1'b1, 1'b1);
        checks++;
        if (barrel_req === 1'b1 && curr_h === 10'd16) begin
            passed++;
        end else begin
            $display("FAIL req_direct: got req=%b h=%0d, want req=1 h=16", barrel_req, curr_h);
        end
        for (int i = 0; i < 10; i++) begin
            frame();
            expect_now("req_hold", 16, 2'b00, 1'b1, 1'b1);
        end

        barrel_ack = 1'b1;
        @(posedge clk); #1;
        barrel_ack = 1'b0;
        wk = 0;
        expect_now("ack", 16, wsel(wk), 1'b0, 1'b1);

        hx = 16;
        for (int i = 0; i < 21; i++) begin
            frame(); wk++; hx += 4;
            expect_now("walk_r", hx, wsel(wk), 1'b0, 1'b1);
        end

        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            frame();
            expect_now("freeze", 100, wsel(wk), 1'b0, 1'b0);
        end
        run = 1'b1;
        frame(); wk++; hx = 104;
        expect_now("unfreeze", 104, wsel(wk), 1'b0, 1'b1);

        while (hx < 200) begin
            frame(); wk++; hx += 4;
            expect_now("walk_r2", hx, wsel(wk), 1'b0, 1'b1);
        end
        frame();
        expect_now("clamp_r", 202, 2'b00, 1'b0, 1'b1);
        frame();
        frame();
        expect_now("stand2", 202, 2'b00, 1'b0, 1'b1);
        frame();
        expect_now("req2", 202, 2'b00, 1'b1, 1'b1);

        barrel_ack = 1'b1;
        vcount = 10'd480;
        @(posedge clk); #1;
        barrel_ack = 1'b0;
        vcount = 10'd100;
        @(posedge clk); #1;
        wk = 0;
        expect_now("ack_tick", 202, wsel(wk), 1'b0, 1'b1);

        frame(); wk++; hx = 198;
        expect_now("left_first", 198, wsel(wk), 1'b0, 1'b1);

        rst_n = 1'b0;
        #1;
        checks++;
        if (curr_h === 10'd16) begin
            passed++;
        end else begin
            $display("FAIL async_rst_walk_h: got h=%0d, want h=16", curr_h);
        end
        checks++;
        if (sprite_selec === 2'b00) begin
            passed++;
        end else begin
            $display("FAIL async_rst_walk_sel: got sel=%b, want sel=00", sprite_selec);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        frame();
        frame();
        frame();
        expect_now("req_after_walk_rst", 16, 2'b00, 1'b1, 1'b1);
        barrel_ack = 1'b1;
        @(posedge clk); #1;
        barrel_ack = 1'b0;
        wk = 0;
        expect_now("ack_after_rst", 16, wsel(wk), 1'b0, 1'b1);
        hx = 16;
        while (hx < 200) begin
            frame(); wk++; hx += 4;
            expect_now("walk_r3", hx, wsel(wk), 1'b0, 1'b1);
        end
        frame();
        expect_now("clamp_r3", 202, 2'b00, 1'b0, 1'b1);
        frame();
        frame();
        frame();
        expect_now("req4", 202, 2'b00, 1'b1, 1'b1);
        barrel_ack = 1'b1;
        @(posedge clk); #1;
        barrel_ack = 1'b0;
        wk = 0;
        expect_now("ack4", 202, wsel(wk), 1'b0, 1'b1);
        frame(); wk++; hx = 198;
        expect_now("left_first2", 198, wsel(wk), 1'b0, 1'b1);

        barrel_ack = 1'b1;
        @(posedge clk); #1;
        barrel_ack = 1'b0;
        expect_now("ack_idle", 198, wsel(wk), 1'b0, 1'b1);

        while (hx > 18) begin
            frame(); wk++; hx -= 4;
            expect_now("walk_l", hx, wsel(wk), 1'b0, 1'b1);
        end
        frame();
        expect_now("clamp_l", 16, 2'b00, 1'b0, 1'b1);
        frame();
        frame();
        frame();
        expect_now("req3", 16, 2'b00, 1'b1, 1'b1);

        rst_n = 1'b0;
        #1;
        checks++;
        if (barrel_req === 1'b0) begin
            passed++;
        end else begin
            $display("FAIL async_rst_req: got req=%b, want req=0", barrel_req);
        end
        checks++;
        if (curr_v === 10'd24) begin
            passed++;
        end else begin
            $display("FAIL async_rst_v: got v=%0d, want v=24", curr_v);
        end
        expect_now("async_rst", 16, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;
        frame();
        expect_now("post_rst", 16, 2'b00, 1'b0, 1'b1);

        if (checks == 0 || passed != checks) begin
            $display("FAIL summary: got %0d/%0d passed, want all passed", passed, checks);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dk_motion_ctrl.md
# dk_motion_ctrl

Frame-synchronous motion and animation controller for Donkey Kong. It sits directly upstream of the Donkey Kong sprite renderer, which draws a 64×32 sprite at the given position with the given pose. Each frame it produces the sprite's top-left position (`curr_h`, `curr_v`), the pose select (`sprite_selec`) and the draw-enable (`bounds_draw`). It paces DK left and right along the top girder, stands to throw a barrel, and handshakes each throw with the barrel spawner.

## Interface
Parameters:
- `X_MIN`, default 16: leftmost `curr_h`.
- `X_MAX`, default 576: rightmost `curr_h`; must satisfy `X_MAX ≤ H_ACTIVE − SPRITE_W`.
- `Y_POS`, default 24: fixed `curr_v`.
- `STEP`, default 2: pixels moved per frame while walking; range 1..15.
- `STAND_FRAMES`, default 60: frames spent standing before each throw.
- `ANIM_FRAMES`, default 8: frames per walk pose; used only with `DK_WALK_ANIM_EN`.

Ports:
- `clk`  in  1: pixel clock, the same clock that drives `hcount`/`vcount`.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `hcount`  in  10: VGA horizontal counter.
- `vcount`  in  10: VGA vertical counter.
- `run`  in  1: game running; low freezes all motion.
- `barrel_ack`  in  1: spawner accepted the throw.
- `curr_h`  out  10: sprite x position.
- `curr_v`  out  10: sprite y position.
- `sprite_selec`  out  2: pose; 00 = stand, 01 = side.
- `bounds_draw`  out  1: draw enable.
- `barrel_req`  out  1: throw request.

## Operation
Frame tick:
- `frame_tick` is combinational: `vblank & ~vblank_q`, where `vblank = (vcount >= V_ACTIVE)` and `vblank_q` is the registered `vblank`.
- It fires once per frame, at the start of vertical blank.
- Positions change only on `frame_tick`, so a visible frame never tears.
- Ticks are ignored while `run` = 0. The FSM holds its state, and `barrel_req` stays at its current value.

FSM states: `S_STAND`, `S_THROW`, `S_WALK`. A direction bit `dir` holds the walk direction (0 = right).
- **`S_STAND`**
  - `sprite_selec` = 00.
  - `stand_cnt` increments on each tick.
  - On the tick where `stand_cnt == STAND_FRAMES−1`: clear `stand_cnt`, set `barrel_req` = 1, go to `S_THROW`.
- **`S_THROW`**
  - `sprite_selec` = 00; `barrel_req` held at 1.
  - `barrel_ack` is sampled only while `barrel_req` = 1.
  - On ack: `barrel_req` ← 0, go to `S_WALK`.
  - If ack and a tick occur in the same cycle, ack wins and there is no movement that cycle.
- **`S_WALK`**
  - `sprite_selec` = 01.
  - On each tick, `curr_h` moves by `STEP` in direction `dir`.
  - Arithmetic is 11-bit, so there is no wrap:
    - Right: if `curr_h + STEP ≥ X_MAX`, then `curr_h` ← `X_MAX`, `dir` ← 1, go to `S_STAND`.
    - Left: if `curr_h < X_MIN + STEP`, then `curr_h` ← `X_MIN`, `dir` ← 0, go to `S_STAND`.
- `curr_v` is constant at `Y_POS`.
- `bounds_draw` = `(hcount < H_ACTIVE) && (vcount < V_ACTIVE) && run_q`, where `run_q` is `run` registered on `frame_tick`. DK therefore appears and disappears only on frame boundaries.

## Timing
- Reset values: `curr_h` = `X_MIN`, `curr_v` = `Y_POS`, `sprite_selec` = 00, `barrel_req` = 0, `state` = `S_STAND`, `dir` = 0, all counters 0, `vblank_q` = 0, `run_q` = 0.
- Latency: the first cycle with `vcount == V_ACTIVE` produces `frame_tick`. All registered outputs update at the clock edge ending that cycle.
- Handshake latency: `barrel_req` falls on the edge after the cycle in which `barrel_ack` = 1. Ack may arrive in the first cycle that req is high. `barrel_ack` while req = 0 is ignored.
- Reset asserted mid-walk or mid-throw returns all outputs to their reset values immediately (asynchronous). Any request in flight is dropped.
- `bounds_draw` is combinational from `hcount`/`vcount`. It carries zero latency relative to the VGA counters.

## Configuration
`DK_WALK_ANIM_EN`:
- Defined: in `S_WALK`, `sprite_selec` alternates 01 and 00 every `ANIM_FRAMES` ticks, starting at 01 on entry. `anim_cnt` resets on entry to `S_WALK`.
- Undefined: `sprite_selec` is constantly 01 in `S_WALK`, and `anim_cnt` is not built.

## Structure
- Package `dk_pkg` holds:
  - the state enum `dk_state_t`;
  - `SPR_STAND` = 2'b00, `SPR_SIDE` = 2'b01;
  - `H_ACTIVE` = 640, `V_ACTIVE` = 480;
  - `SPRITE_W` = 64, `SPRITE_H` = 32.
- Sub-module `dk_frame_tick` contains the `vblank` edge detector. It is reused by later sprite controllers.

## Test plan
All scenarios use `X_MIN` = 16, `X_MAX` = 202, `STEP` = 4, `STAND_FRAMES` = 3, `Y_POS` = 24, `run` = 1 unless stated.
1. **Reset:** assert `rst_n` = 0 mid-frame → `curr_h` = 16, `curr_v` = 24, `sprite_selec` = 00, `barrel_req` = 0, all asynchronously.
2. **Stand then request:** apply 3 frame ticks → `barrel_req` = 1 after the 3rd. Keep ack low for 10 frames → req stays 1 and `curr_h` stays 16.
3. **Ack and first step:** pulse `barrel_ack` for one cycle → req = 0 next edge. Next tick gives `curr_h` = 20, `sprite_selec` = 01.
4. **Right clamp and reversal:**
   - Walking right reaches `curr_h` = 200; the next tick clamps to 202 and enters `S_STAND`.
   - After the stand and throw, the first left step gives `curr_h` = 198.
5. **Freeze:** hold `run` = 0 for 5 ticks mid-walk at `curr_h` = 100 → `curr_h` stays 100 and `bounds_draw` = 0 from the next tick. Release `run` → `curr_h` = 104 on the following tick.
6. **Walk animation:** with `DK_WALK_ANIM_EN` and `ANIM_FRAMES` = 2 → walk sprite sequence 01, 01, 00, 00, 01. Without the macro → constant 01.
